// File: rtl/jedro_1_prefetch.sv
// jedro_1_prefetch: instruction prefetch unit.
// Fetches sequential words from a single-cycle instruction memory into a
// 2-entry FIFO and presents them to the decoder. It supports redirects
// (jumps/taken branches) from execute, which flush the FIFO and drop any
// response still on its way back from memory.
module jedro_1_prefetch #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // instruction memory side
    output logic                  imem_rd_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    // decoder side
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    // redirect from execute
    input  logic                  jmp_instr_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LP_INC   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] LP_ALIGN = ~ADDR_WIDTH'(3);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;

    // Tracker for the request issued last cycle, whose data is on imem_rdata_i now
    logic                  r_inflight;
    logic                  r_discard;
    logic [ADDR_WIDTH-1:0] r_inflight_addr;

    // 2-entry FIFO, entry 0 is always the head (shift-on-pop)
    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [ADDR_WIDTH-1:0] r_addr1;

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_occupancy;
    logic                  w_rd;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_pop    = (r_count != 2'd0) && instr_ready_i;
    // A redirect flushes the FIFO at the end of this cycle, so the arriving
    // response is dropped as well.
    assign w_push   = r_inflight && !r_discard && !jmp_instr_i;
    // Low address bits of the redirect target are forced to zero.
    assign w_target = jmp_addr_i & LP_ALIGN;

    // Slots committed after this cycle: buffered words plus the one returning,
    // minus the one the decoder takes now. Pop implies count >= 1, so no underflow.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Fetch request: always in the boot cycle; in RUN only when the result is
    // guaranteed a FIFO slot and no redirect is being taken.
    always_comb begin
        w_rd = 1'b0;
        if (rst_i) begin
            w_rd = 1'b0;
        end else if (r_state == ST_BOOT) begin
            w_rd = 1'b1;
        end else begin
            w_rd = !jmp_instr_i && (w_occupancy < 3'd2);
        end
    end

    assign imem_rd_o     = w_rd;
    assign imem_addr_o   = r_pc;
    assign instr_valid_o = (r_count != 2'd0);
    assign instr_o       = r_data0;
    assign instr_addr_o  = r_addr0;

    // Boot/run sequencing: one boot cycle after reset, then run forever
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_BOOT;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    // Program counter: redirect wins, otherwise advance on every issued fetch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc <= BOOT_ADDR;
        end else if (jmp_instr_i) begin
            r_pc <= w_target;
        end else if (w_rd) begin
            r_pc <= r_pc + LP_INC;
        end
    end

    // In-flight tracking; a fetch issued alongside a redirect (boot cycle) is dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight      <= 1'b0;
            r_discard       <= 1'b0;
            r_inflight_addr <= '0;
        end else begin
            r_inflight <= w_rd;
            r_discard  <= w_rd && jmp_instr_i;
            if (w_rd) begin
                r_inflight_addr <= r_pc;
            end
        end
    end

    // FIFO update: flush on redirect, else push/pop with order preserved
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_addr0 <= '0;
            r_addr1 <= '0;
        end else if (jmp_instr_i) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= imem_rdata_i;
                        r_addr0 <= r_inflight_addr;
                    end else begin
                        r_data1 <= imem_rdata_i;
                        r_addr1 <= r_inflight_addr;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_addr0 <= r_addr1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= imem_rdata_i;
                        r_addr0 <= r_inflight_addr;
                    end else begin
                        r_data0 <= r_data1;
                        r_addr0 <= r_addr1;
                        r_data1 <= imem_rdata_i;
                        r_addr1 <= r_inflight_addr;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

// File: doc/jedro_1_prefetch.md
JEDRO_1_PREFETCH -- requirements
Module: jedro_1_prefetch

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, instruction address width.
REQ-002 Parameter: DATA_WIDTH, 32, instruction word width.
REQ-003 Parameter: BOOT_ADDR, 32'h0000_0000, first fetch address after reset; low 2 bits SHALL be 0.
REQ-004 clk_i  in  1  single clock; all state changes on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous assert, active-high; synchronous deassert is external.
REQ-006 imem_rd_o  out  1  instruction memory read request this cycle.
REQ-007 imem_addr_o  out  ADDR_WIDTH  word-aligned fetch address, valid when imem_rd_o=1.
REQ-008 imem_rdata_i  in  DATA_WIDTH  read data, valid the cycle after a request; no stall from memory.
REQ-009 instr_o  out  DATA_WIDTH  instruction at buffer head.
REQ-010 instr_addr_o  out  ADDR_WIDTH  address of instr_o.
REQ-011 instr_valid_o  out  1  buffer head valid for the decoder.
REQ-012 instr_ready_i  in  1  decoder accepts head; transfer when instr_valid_o && instr_ready_i.
REQ-013 jmp_instr_i  in  1  redirect request (jump/branch taken) from execute.
REQ-014 jmp_addr_i  in  ADDR_WIDTH  redirect target; bits [1:0] ignored, treated as 0.

Function
REQ-015 Block SHALL hold PC register, 2-entry instruction FIFO (data+address per entry), 1-bit in-flight flag, 1-bit discard flag.
REQ-016 FSM states: BOOT (first cycle after reset), RUN; BOOT->RUN unconditionally after one cycle; no other transitions.
REQ-017 In BOOT: imem_rd_o=1, imem_addr_o=BOOT_ADDR.
REQ-018 In RUN: imem_rd_o=1 iff !jmp_instr_i and (count + inflight - pop) < 2, pop = instr_valid_o && instr_ready_i.
REQ-019 imem_addr_o SHALL equal PC; PC += 4 on each cycle imem_rd_o=1; ADDR_WIDTH-bit wrap-around at top of address space, no flag.
REQ-020 Response to request issued in cycle N SHALL be written into FIFO at end of cycle N+1 unless discarded; instr_valid_o for it no earlier than cycle N+2.
REQ-021 instr_valid_o = (count != 0); instr_o/instr_addr_o registered from FIFO head, no combinational path from imem_rdata_i.
REQ-022 Simultaneous push and pop SHALL keep count unchanged and order preserved; FIFO SHALL never overflow (guaranteed by REQ-018) nor pop when empty.
REQ-023 Steady state with instr_ready_i=1 SHALL sustain one instruction per cycle.
REQ-024 instr_ready_i=0 SHALL hold instr_o/instr_addr_o stable until accepted.
REQ-025 jmp_instr_i=1 in cycle C: pop in C (if any) completes; at end of C FIFO cleared, PC <= {jmp_addr_i[ADDR_WIDTH-1:2],2'b00}, response to any request in flight from C-1 or C marked discarded.
REQ-026 After redirect in C: instr_valid_o=0 in C+1 and C+2; imem_rd_o=1 with target address in C+1; target instruction valid in C+3.
REQ-027 Back-to-back jmp_instr_i: last one wins; each cycle re-applies REQ-025.
REQ-028 jmp_instr_i in BOOT SHALL be honoured identically (boot fetch discarded).

Reset
REQ-029 While rst_i=1: state=BOOT, PC=BOOT_ADDR, FIFO count=0, inflight=0, discard=0, instr_valid_o=0, instr_o=0, instr_addr_o=0, imem_rd_o=0, imem_addr_o=BOOT_ADDR.
REQ-030 rst_i asserted mid-operation SHALL immediately clear all state per REQ-029; rst_i overrides jmp_instr_i; late responses to pre-reset requests SHALL be ignored.

Verification
REQ-031 Reset release, BOOT_ADDR=0, ROM word[k]=k, ready=1 -> imem_rd_o first cycle addr 0; instr_valid_o in cycle 2 with instr_o=0, addr 0; then one instruction per cycle, addresses 0,4,8,...
REQ-032 ready=0 for 5 cycles after first valid -> at most 2 words buffered, imem_rd_o deasserts, instr_o stays 0; on ready=1 stream resumes 0,4,8 with no gap or duplicate.
REQ-033 Streaming, jmp_instr_i=1 jmp_addr_i=32'h0000_0102 in cycle C -> valid=0 in C+1,C+2; imem_addr_o=32'h100 in C+1; C+3 instr_addr_o=32'h100, instr_o=word[64]; no pre-jump word after C.
REQ-034 jmp_instr_i two consecutive cycles to 0x40 then 0x80 -> first delivered instr_addr_o=0x80; 0x40 never delivered.
REQ-035 PC=32'hFFFF_FFFC streaming -> next fetch address 32'h0000_0000, instr_addr_o sequence FFFF_FFFC, 0000_0000.
REQ-036 rst_i pulsed while FIFO full and fetch in flight -> outputs per REQ-029 same cycle; after release restart at BOOT_ADDR, no stale word delivered.
